// File: rtl/conv_weight_loader.sv
// Serial loader for conv1 kernel parameters: 25 weights plus a bias fill a
// shadow bank, which is copied to the active outputs only on a frame-boundary swap.
module conv_weight_loader #(
    parameter int NUM_KERNELS = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic signed [8:0] s_data,
    input  logic              s_last,
    input  logic              swap_en,
    output logic [44:0]       weight_m_1,
    output logic [44:0]       weight_m_2,
    output logic [44:0]       weight_m_3,
    output logic [44:0]       weight_m_4,
    output logic [44:0]       weight_m_5,
    output logic signed [8:0] bias,
    output logic              params_valid,
    output logic              pending,
    output logic [2:0]        kernel_idx,
    output logic              err_len
);

    typedef enum logic {LOAD, FULL} state_t;

    localparam logic [2:0] LAST_KERNEL = 3'(NUM_KERNELS - 1);

    state_t              state_q;
    logic [2:0]          r_q, c_q, r_d, c_d;
    logic                biasPhase_q, biasPhase_d;
    logic [44:0]         shadow_q [5];
    logic signed [8:0]   shadowBias_q;
    logic [44:0]         active_q [5];
    logic signed [8:0]   bias_q;
    logic                paramsValid_q;
    logic [2:0]          kernelIdx_q;
    logic                errLen_q;

    // Column index runs fastest; the word after (4,4) is the bias.
    always_comb begin
        r_d         = r_q;
        c_d         = c_q;
        biasPhase_d = biasPhase_q;
        if (c_q == 3'd4) begin
            c_d = 3'd0;
            if (r_q == 3'd4) begin
                r_d         = 3'd0;
                biasPhase_d = 1'b1;
            end else begin
                r_d = r_q + 3'd1;
            end
        end else begin
            c_d = c_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= LOAD;
            r_q           <= 3'd0;
            c_q           <= 3'd0;
            biasPhase_q   <= 1'b0;
            shadowBias_q  <= '0;
            bias_q        <= '0;
            paramsValid_q <= 1'b0;
            kernelIdx_q   <= 3'd0;
            errLen_q      <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (s_valid) begin
                        if (!biasPhase_q) begin
                            if (s_last) begin
                                errLen_q <= 1'b1;
                                r_q      <= 3'd0;
                                c_q      <= 3'd0;
                                for (int i = 0; i < 5; i++) shadow_q[i] <= '0;
                            end else begin
                                // Row 0 sits in the MSBs of each column word.
                                for (int cc = 0; cc < 5; cc++) begin
                                    for (int rr = 0; rr < 5; rr++) begin
                                        if (c_q == 3'(cc) && r_q == 3'(rr))
                                            shadow_q[cc][44-9*rr -: 9] <= s_data;
                                    end
                                end
                                r_q         <= r_d;
                                c_q         <= c_d;
                                biasPhase_q <= biasPhase_d;
                            end
                        end else begin
                            r_q         <= 3'd0;
                            c_q         <= 3'd0;
                            biasPhase_q <= 1'b0;
                            if (s_last) begin
                                shadowBias_q <= s_data;
                                state_q      <= FULL;
                            end else begin
                                errLen_q <= 1'b1;
                            end
                        end
                    end
                end
                FULL: begin
                    if (swap_en) begin
                        for (int i = 0; i < 5; i++) active_q[i] <= shadow_q[i];
                        bias_q        <= shadowBias_q;
                        paramsValid_q <= 1'b1;
                        // The first commit after reset names kernel 0.
                        if (!paramsValid_q || kernelIdx_q == LAST_KERNEL)
                            kernelIdx_q <= 3'd0;
                        else
                            kernelIdx_q <= kernelIdx_q + 3'd1;
                        state_q <= LOAD;
                    end
                end
            endcase
        end
    end

    assign s_ready      = (state_q == LOAD);
    assign pending      = (state_q == FULL);
    assign weight_m_1   = active_q[0];
    assign weight_m_2   = active_q[1];
    assign weight_m_3   = active_q[2];
    assign weight_m_4   = active_q[3];
    assign weight_m_5   = active_q[4];
    assign bias         = bias_q;
    assign params_valid = paramsValid_q;
    assign kernel_idx   = kernelIdx_q;
    assign err_len      = errLen_q;

endmodule

// File: tb/tb_conv_weight_loader.sv
// Self-checking bench for conv_weight_loader: table-driven kernel rounds plus
// hand-written corner sequences, with a scoreboard of expected commits.
module tb_conv_weight_loader;

    localparam int NK = 6;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [8:0]        s_data = '0;
    logic              s_last = 1'b0;
    logic              swap_en = 1'b0;
    logic [44:0]       weight_m_1, weight_m_2, weight_m_3, weight_m_4, weight_m_5;
    logic [8:0]        bias;
    logic              params_valid, pending, err_len;
    logic [2:0]        kernel_idx;

    conv_weight_loader #(.NUM_KERNELS(NK)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .swap_en(swap_en),
        .weight_m_1(weight_m_1), .weight_m_2(weight_m_2), .weight_m_3(weight_m_3),
        .weight_m_4(weight_m_4), .weight_m_5(weight_m_5), .bias(bias),
        .params_valid(params_valid), .pending(pending),
        .kernel_idx(kernel_idx), .err_len(err_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0][44:0] cols;
        logic [8:0]       bias;
        logic [2:0]       kidx;
    } exp_t;

    typedef struct {
        int         base;
        logic [8:0] bias;
        bit         rnd;
        bit         swapOnBias;
        logic [2:0] kidx;
    } vec_t;

    exp_t sb[$];
    exp_t lastExp;
    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;
    int   kModel = -1;

    // Column c holds w[0][c]..w[4][c] MSB-first, with w[r][c] = base + 5r + c.
    function automatic logic [44:0] makeCol(int base, int c);
        return {9'(base + c), 9'(base + 5 + c), 9'(base + 10 + c),
                9'(base + 15 + c), 9'(base + 20 + c)};
    endfunction

    function automatic logic [2:0] nextK();
        kModel = (kModel < 0) ? 0 : (kModel + 1) % NK;
        return 3'(kModel);
    endfunction

    task automatic checkOutput(input string name, input logic [44:0] act, input logic [44:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, " w_m1"}, weight_m_1, 45'd0);
        checkOutput({tag, " w_m5"}, weight_m_5, 45'd0);
        checkOutput({tag, " bias"}, 45'(bias), 45'd0);
        checkOutput({tag, " params_valid"}, 45'(params_valid), 45'd0);
        checkOutput({tag, " pending"}, 45'(pending), 45'd0);
        checkOutput({tag, " kernel_idx"}, 45'(kernel_idx), 45'd0);
        checkOutput({tag, " err_len"}, 45'(err_len), 45'd0);
    endtask

    task automatic sendWord(input logic [8:0] d, input logic l, input logic sw, input bit rnd);
        int budget;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_data  = 9'($urandom);
                s_last  = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        swap_en = sw;
        budget  = 0;
        while (!s_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!s_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL handshake timeout: s_ready got 0 expected 1");
        end else begin
            @(posedge clk);
        end
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        swap_en = 1'b0;
    endtask

    // Streams one 26-word kernel and records what its commit must show.
    task automatic applyStimulus(input int base, input logic [8:0] b, input bit rnd,
                                 input bit swapOnBias, input logic [2:0] kidx);
        exp_t e;
        for (int n = 0; n < 25; n++) sendWord(9'(base + n), 1'b0, 1'b0, rnd);
        sendWord(b, 1'b1, swapOnBias, rnd);
        for (int c = 0; c < 5; c++) e.cols[c] = makeCol(base, c);
        e.bias = b;
        e.kidx = kidx;
        sb.push_back(e);
    endtask

    task automatic doSwap(input string tag);
        exp_t e;
        @(negedge clk);
        checkOutput({tag, " pending before swap"}, 45'(pending), 45'd1);
        checkOutput({tag, " active held before swap"}, weight_m_1, lastExp.cols[0]);
        swap_en = 1'b1;
        @(posedge clk);
        #1 swap_en = 1'b0;
        @(negedge clk);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, " w_m1"}, weight_m_1, e.cols[0]);
            checkOutput({tag, " w_m2"}, weight_m_2, e.cols[1]);
            checkOutput({tag, " w_m3"}, weight_m_3, e.cols[2]);
            checkOutput({tag, " w_m4"}, weight_m_4, e.cols[3]);
            checkOutput({tag, " w_m5"}, weight_m_5, e.cols[4]);
            checkOutput({tag, " bias"}, 45'(bias), 45'(e.bias));
            checkOutput({tag, " kernel_idx"}, 45'(kernel_idx), 45'(e.kidx));
            checkOutput({tag, " params_valid"}, 45'(params_valid), 45'd1);
            checkOutput({tag, " s_ready after swap"}, 45'(s_ready), 45'd1);
            checkOutput({tag, " pending after swap"}, 45'(pending), 45'd0);
            lastExp = e;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global timeout: simulation got stuck expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{1,    9'h1FD, 1'b0, 1'b1, 3'd0};
        vecs[1] = '{-12,  9'd100, 1'b1, 1'b0, 3'd1};
        vecs[2] = '{200,  9'h100, 1'b1, 1'b0, 3'd2};
        vecs[3] = '{-250, 9'd7,   1'b0, 1'b0, 3'd3};
        vecs[4] = '{37,   9'h0FF, 1'b1, 1'b0, 3'd4};
        vecs[5] = '{100,  9'h1FF, 1'b0, 1'b0, 3'd5};
        vecs[6] = '{-1,   9'd0,   1'b1, 1'b0, 3'd0};
        for (int c = 0; c < 5; c++) lastExp.cols[c] = '0;
        lastExp.bias = '0;
        lastExp.kidx = '0;

        #12;
        checkZero("in reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkZero("after reset");
        checkOutput("s_ready after reset", 45'(s_ready), 45'd1);

        // Seven load/swap rounds; round 0 also raises swap_en on the bias edge.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].base, vecs[i].bias, vecs[i].rnd, vecs[i].swapOnBias, vecs[i].kidx);
            kModel = int'(vecs[i].kidx);
            @(negedge clk);
            checkOutput($sformatf("round%0d s_ready in FULL", i), 45'(s_ready), 45'd0);
            checkOutput($sformatf("round%0d params_valid pre", i), 45'(params_valid), 45'(i > 0));
            doSwap($sformatf("round%0d", i));
        end

        // FULL held for 20 cycles against a persistent s_valid.
        applyStimulus(50, 9'h1AB, 1'b0, 1'b0, nextK());
        @(negedge clk);
        s_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            s_data = 9'($urandom);
            s_last = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("hold s_ready", 45'(s_ready), 45'd0);
            checkOutput("hold w_m3", weight_m_3, lastExp.cols[2]);
            checkOutput("hold bias", 45'(bias), 45'(lastExp.bias));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        doSwap("hold");

        // Missing s_last on the 26th word is a framing error.
        for (int n = 0; n < 26; n++) sendWord(9'(n), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("nolast err_len", 45'(err_len), 45'd1);
        checkOutput("nolast s_ready", 45'(s_ready), 45'd1);
        checkOutput("nolast pending", 45'(pending), 45'd0);
        applyStimulus(-100, 9'h055, 1'b1, 1'b0, nextK());
        doSwap("after nolast");

        // Reset after 12 words drops the partial kernel.
        for (int n = 0; n < 12; n++) sendWord(9'(300 + n), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        #2;
        checkZero("mid-load reset");
        @(negedge clk);
        rstn   = 1'b1;
        kModel = -1;
        for (int c = 0; c < 5; c++) lastExp.cols[c] = '0;
        lastExp.bias = '0;
        @(negedge clk);
        checkOutput("post reset s_ready", 45'(s_ready), 45'd1);

        // s_last on the 10th word, then a clean load.
        for (int n = 0; n < 9; n++) sendWord(9'(n + 70), 1'b0, 1'b0, 1'b0);
        sendWord(9'd79, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("early last err_len", 45'(err_len), 45'd1);
        checkOutput("early last s_ready", 45'(s_ready), 45'd1);
        checkOutput("early last params_valid", 45'(params_valid), 45'd0);
        applyStimulus(1, 9'h1FD, 1'b0, 1'b0, nextK());
        doSwap("after early last");
        checkOutput("err_len sticky", 45'(err_len), 45'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
